// File: rtl/rom_fetch_pkg.sv
// Shared fetch-side types and constants for the rv32i instruction front end.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_DRAIN,
        FETCH_REQ,
        FETCH_WAIT
    } fetch_state_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/rom_fetch_buf.sv
// One-entry valid/ready holding buffer between the ROM fetcher and decode.
module rom_fetch_buf
    import rom_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_pc,
    output logic        space
);

    // Space exists when empty or when the held word leaves this cycle.
    assign space = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_pc    <= 32'h0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_pc    <= load_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_fetch.sv
// Instruction-fetch initiator: one outstanding ROM read, redirect handling,
// and a one-entry buffer towards decode.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DELAY    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_oe,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CNT_W = $clog2(DELAY + 1) + 1;

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      pc_req;
    logic             stale;
    logic [CNT_W-1:0] drain_cnt;
    logic             buf_space;
    logic             buf_load;
    logic [31:0]      redirect_target;

    assign redirect_target = align_pc(redirect_pc);
    assign mem_re   = reset_n & (state == FETCH_REQ) & buf_space & ~redirect_valid;
    assign mem_addr = (state == FETCH_WAIT) ? pc_req : pc;
    assign buf_load = (state == FETCH_WAIT) & mem_oe & ~stale & ~redirect_valid;

    rom_fetch_buf u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .load      (buf_load),
        .load_data (mem_data),
        .load_pc   (pc_req),
        .out_ready (inst_ready),
        .out_valid (inst_valid),
        .out_data  (inst),
        .out_pc    (inst_pc),
        .space     (buf_space)
    );

    // The ROM has no reset, so after reset wait out any read it may still be serving.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= FETCH_DRAIN;
            pc        <= align_pc(RESET_PC);
            pc_req    <= 32'h0;
            stale     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                FETCH_DRAIN: begin
                    if (drain_cnt == CNT_W'(DELAY)) state <= FETCH_REQ;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                FETCH_REQ: begin
                    if (mem_re) begin
                        state  <= FETCH_WAIT;
                        pc_req <= pc;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_oe) begin
                        state <= FETCH_REQ;
                        stale <= 1'b0;
                        if (buf_load) pc <= pc_req + INST_BYTES;
                    end else if (redirect_valid) begin
                        stale <= 1'b1;
                    end
                end
                default: state <= FETCH_DRAIN;
            endcase
            if (redirect_valid) pc <= redirect_target;
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: two instances (DELAY 0 and 3) share one stimulus, each with
// its own ROM and a behavioural fetch model compared every cycle.
module tb_rom_fetch;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        inst_ready     = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    int          d_pass  = 0;
    int          d_total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D = (g == 0) ? 0 : 3;
        logic        mem_re, mem_oe, inst_valid;
        logic [31:0] mem_addr, mem_data, inst, inst_pc;
        logic        rom_v [D+1];
        logic [31:0] rom_a [D+1];
        int          n_pass  = 0;
        int          n_total = 0;
        logic        m_live  = 1'b0;
        logic        m_busy, m_stale, m_bv;
        int          m_drain;
        logic [31:0] m_fpc, m_rpc, m_bpc, m_seq;
        logic        c_re, c_acc, c_load;

        rom_fetch #(.RESET_PC(32'h0000_0000), .DELAY(D)) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .mem_re         (mem_re),
            .mem_addr       (mem_addr),
            .mem_data       (mem_data),
            .mem_oe         (mem_oe),
            .inst_valid     (inst_valid),
            .inst_ready     (inst_ready),
            .inst           (inst),
            .inst_pc        (inst_pc),
            .redirect_valid (redirect_valid),
            .redirect_pc    (redirect_pc)
        );

        // ROM: request in cycle t answers in cycle t+1+D; it is never reset.
        always @(posedge clk) begin
            rom_v[0] <= mem_re;
            rom_a[0] <= mem_addr;
            for (int i = 1; i <= D; i++) begin
                rom_v[i] <= rom_v[i-1];
                rom_a[i] <= rom_a[i-1];
            end
        end
        assign mem_oe   = rom_v[D];
        assign mem_data = rom_v[D] ? rom_word(rom_a[D]) : 32'hDEAD_DEAD;

        task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
            n_total++;
            if (got === exp) n_pass++;
            else $display("FAIL lane%0d %s at %0t: got %h expected %h", g, nm, $time, got, exp);
        endtask

        always @(negedge clk) begin
            if (m_live) begin
                c_re = reset_n && (m_drain == 0) && !m_busy && (!m_bv || inst_ready) && !redirect_valid;
                chk("mem_re", {31'b0, mem_re}, {31'b0, c_re});
                if (c_re) chk("mem_addr", mem_addr, m_fpc);
                chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_bv});
                if (m_bv) begin
                    chk("inst_pc", inst_pc, m_bpc);
                    chk("inst", inst, rom_word(m_bpc));
                end
            end else begin
                c_re = 1'b0;
            end
            if (!reset_n) begin
                m_live = 1'b1; m_drain = D + 1; m_busy = 1'b0; m_stale = 1'b0;
                m_bv = 1'b0; m_bpc = 32'h0; m_fpc = 32'h0; m_rpc = 32'h0; m_seq = 32'h0;
            end else if (m_live) begin
                c_acc  = m_bv && inst_ready;
                c_load = 1'b0;
                if (c_acc) begin
                    chk("program_order_pc", inst_pc, m_seq);
                    m_seq = m_seq + 32'd4;
                end
                if (m_drain > 0) begin
                    m_drain--;
                end else if (c_re) begin
                    m_busy = 1'b1;
                    m_rpc  = m_fpc;
                end else if (m_busy && mem_oe) begin
                    m_busy = 1'b0;
                    if (!m_stale && !redirect_valid) begin
                        c_load = 1'b1;
                        m_fpc  = m_rpc + 32'd4;
                    end
                    m_stale = 1'b0;
                end else if (m_busy && redirect_valid) begin
                    m_stale = 1'b1;
                end
                if (redirect_valid) begin
                    m_bv  = 1'b0;
                    m_fpc = redirect_pc & ~32'd3;
                    m_seq = redirect_pc & ~32'd3;
                end else if (c_load) begin
                    m_bv  = 1'b1;
                    m_bpc = m_rpc;
                end else if (c_acc) begin
                    m_bv = 1'b0;
                end
            end
        end
    end

    task automatic dchk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        d_total++;
        if (got === exp) d_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_re1(input int maxc, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < maxc && !ok; k++) begin
            @(negedge clk);
            if (lane[1].mem_re) ok = 1'b1;
        end
    endtask

    logic        r0_re [12], r0_v [12], r1_re [12], r1_v [12];
    logic [31:0] r0_addr [12], r0_pc [12], r0_inst [12], r1_addr [12];
    int          f0, f1, first, cnt, bad;
    logic        ok, seen8, oe_seen;
    logic [31:0] a, vpc, vinst;
    int          tot, pas;

    initial begin
        // Reset and start-up timing with decode always ready.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            r0_re[k] = lane[0].mem_re;  r0_addr[k] = lane[0].mem_addr;
            r0_v[k]  = lane[0].inst_valid; r0_pc[k] = lane[0].inst_pc; r0_inst[k] = lane[0].inst;
            r1_re[k] = lane[1].mem_re;  r1_addr[k] = lane[1].mem_addr; r1_v[k] = lane[1].inst_valid;
            if (k == 0) begin
                dchk("reset_inst_valid", {31'b0, lane[0].inst_valid}, 32'h0);
                dchk("reset_inst", lane[0].inst, 32'h0);
                dchk("reset_inst_pc", lane[0].inst_pc, 32'h0);
                dchk("reset_inst_d3", lane[1].inst, 32'h0);
            end
        end
        f0 = -1; f1 = -1;
        for (int k = 11; k >= 0; k--) begin
            if (r0_re[k]) f0 = k;
            if (r1_re[k]) f1 = k;
        end
        dchk("first_re_cycle_d0", f0, 1);
        dchk("first_re_addr_d0", r0_addr[1], 32'h0);
        dchk("first_re_cycle_d3", f1, 4);
        dchk("word0_valid_d0", {31'b0, r0_v[3]}, 32'h1);
        dchk("word0_pc_d0", r0_pc[3], 32'h0);
        dchk("word0_data_d0", r0_inst[3], 32'h5A5A_1234);
        dchk("gap_cycle_d0", {31'b0, r0_v[4]}, 32'h0);
        dchk("word1_pc_d0", r0_pc[5], 32'h4);
        dchk("word1_data_d0", r0_inst[5], 32'h2287_F4F0);
        dchk("word0_valid_d3", {31'b0, r1_v[9]}, 32'h1);
        dchk("next_re_same_cycle_d3", {31'b0, r1_re[9]}, 32'h1);
        dchk("next_re_addr_d3", r1_addr[9], 32'h4);

        // Backpressure after the first word.
        do_reset();
        inst_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (lane[1].inst_valid) ok = 1'b1;
        end
        dchk("bp_word_arrives", {31'b0, ok}, 32'h1);
        cnt = 0; bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (lane[1].mem_re) cnt++;
            if (!lane[1].inst_valid || lane[1].inst_pc !== 32'h0 || lane[1].inst !== 32'h5A5A_1234) bad++;
        end
        dchk("bp_no_request", cnt, 0);
        dchk("bp_word_held", bad, 0);
        tick();
        inst_ready = 1'b1;
        @(negedge clk);
        dchk("bp_release_re", {31'b0, lane[1].mem_re}, 32'h1);
        dchk("bp_release_addr", lane[1].mem_addr, 32'h4);

        // Redirect while the read of address 8 is in flight.
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (lane[1].mem_re && lane[1].mem_addr == 32'h8) ok = 1'b1;
        end
        dchk("stale_find_req8", {31'b0, ok}, 32'h1);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        first = -1; a = 32'h0; seen8 = 1'b0; vpc = 32'hFFFF_FFFF;
        for (int k = 3; k < 30; k++) begin
            @(negedge clk);
            if (lane[1].inst_valid && lane[1].inst_pc == 32'h8) seen8 = 1'b1;
            if (lane[1].mem_re && first < 0) begin first = k; a = lane[1].mem_addr; end
            if (lane[1].inst_valid && vpc == 32'hFFFF_FFFF) vpc = lane[1].inst_pc;
        end
        dchk("stale_next_re_cycle", first, 5);
        dchk("stale_next_re_addr", a, 32'h100);
        dchk("stale_pc8_dropped", {31'b0, seen8}, 32'h0);
        dchk("stale_first_word_pc", vpc, 32'h100);

        // Redirect in the same cycle the ROM completes.
        wait_re1(30, ok);
        dchk("oe_find_req", {31'b0, ok}, 32'h1);
        tick();
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        dchk("oe_same_cycle", {31'b0, lane[1].mem_oe}, 32'h1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        dchk("oe_flush_valid", {31'b0, lane[1].inst_valid}, 32'h0);
        dchk("oe_redirect_re", {31'b0, lane[1].mem_re}, 32'h1);
        dchk("oe_redirect_addr", lane[1].mem_addr, 32'h200);
        tick();
        inst_ready = 1'b1;

        // One-cycle reset while the ROM is one cycle into a read.
        wait_re1(30, ok);
        dchk("rst_find_req", {31'b0, ok}, 32'h1);
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        dchk("rst_no_re_in_reset", {31'b0, lane[1].mem_re}, 32'h0);
        tick();
        reset_n = 1'b1;
        cnt = 0; oe_seen = 1'b0; first = -1; a = 32'hFFFF_FFFF;
        vpc = 32'hFFFF_FFFF; vinst = 32'h0;
        for (int k = 2; k < 16; k++) begin
            @(negedge clk);
            if (k < 6 && lane[1].mem_re) cnt++;
            if (k < 6 && lane[1].mem_oe) oe_seen = 1'b1;
            if (lane[1].mem_re && first < 0) begin first = k; a = lane[1].mem_addr; end
            if (lane[1].inst_valid && vpc == 32'hFFFF_FFFF) begin vpc = lane[1].inst_pc; vinst = lane[1].inst; end
        end
        dchk("rst_drain_no_re", cnt, 0);
        dchk("rst_stray_oe_seen", {31'b0, oe_seen}, 32'h1);
        dchk("rst_first_re_cycle", first, 6);
        dchk("rst_first_re_addr", a, 32'h0);
        dchk("rst_first_word_pc", vpc, 32'h0);
        dchk("rst_first_word_data", vinst, 32'h5A5A_1234);

        // PC wrap at the top of the address space.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        wait_re1(30, ok);
        dchk("wrap_find_top", {31'b0, ok}, 32'h1);
        dchk("wrap_top_addr", lane[1].mem_addr, 32'hFFFF_FFFC);
        wait_re1(30, ok);
        dchk("wrap_find_next", {31'b0, ok}, 32'h1);
        dchk("wrap_next_addr", lane[1].mem_addr, 32'h0);

        // Random traffic: backpressure, redirects (some near the wrap point), rare resets.
        for (int k = 0; k < 4000; k++) begin
            tick();
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            reset_n        = ($urandom_range(0, 299) != 0);
        end
        tick();
        reset_n = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        repeat (12) @(negedge clk);

        tot = d_total + lane[0].n_total + lane[1].n_total;
        pas = d_pass + lane[0].n_pass + lane[1].n_pass;
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end

endmodule

// File: doc/rom_fetch.md
Name: rom_fetch

Overview:
- Instruction-fetch initiator for the single-port instruction ROM. It issues one read at a time using the re/addr request and oe completion handshake.
- Captures returned words into a one-entry output buffer and hands them to decode with a valid/ready handshake.
- Handles control-flow redirects. Any read already in flight is discarded when it completes.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DELAY, 0, ROM response delay. Must equal the DELAY of the attached ROM.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- mem_re  out  1  read request to ROM, one-cycle pulse
- mem_addr  out  32  byte address to ROM, valid while mem_re=1
- mem_data  in  32  ROM read data, valid while mem_oe=1
- mem_oe  in  1  ROM completion pulse
- inst_valid  out  1  output buffer holds an instruction
- inst_ready  in  1  decode accepts the instruction this cycle
- inst  out  32  buffered instruction word
- inst_pc  out  32  byte address of inst
- redirect_valid  in  1  replace the fetch PC this cycle
- redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0

Behaviour:
- Reset:
  - reset_n=0 sampled at a clk edge gives state=DRAIN, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, stale=0, drain counter=0.
  - mem_re=0 while reset_n=0 and throughout DRAIN.
- States: DRAIN, REQ, WAIT.
- DRAIN:
  - The ROM has no reset, so a read can still be in progress in it.
  - Stay in DRAIN DELAY+1 cycles, ignoring mem_oe, then go to REQ.
  - With DELAY=0, DRAIN lasts 1 cycle.
- REQ:
  - Define space = ~inst_valid | inst_ready.
  - mem_re = space & ~redirect_valid, combinational. mem_addr = pc.
  - If mem_re=1, next state is WAIT and pc_req <= pc. Otherwise stay in REQ.
- WAIT:
  - mem_re=0 and mem_addr holds pc_req.
  - On mem_oe=1 with stale=0 and no redirect: inst <= mem_data, inst_pc <= pc_req, inst_valid <= 1, pc <= pc_req+4, next state REQ.
  - On mem_oe=1 with stale=1: drop the data, clear stale, next state REQ.
- Latency:
  - mem_re at cycle t, then mem_oe at t+1+DELAY, then inst_valid at t+2+DELAY.
  - The next mem_re can issue in the same cycle inst_valid rises, if inst_ready=1.
- Output handshake:
  - inst_valid clears on inst_valid & inst_ready unless a new word loads in the same cycle.
  - inst and inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Redirect (priority over everything except reset):
  - pc <= {redirect_pc[31:2],2'b00}. inst_valid <= 0 next cycle, including any word that would have loaded that cycle.
  - In WAIT with mem_oe=0: stale <= 1.
  - In WAIT with mem_oe=1: data dropped, next state REQ.
  - In REQ: no request issues that cycle.
  - Back-to-back redirects: the last one wins.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). Bits [1:0] of pc are always 0.
- mem_oe outside WAIT (DRAIN, REQ): ignored, no state change.

Decomposition:
- In the shared rv32i package:
  - fetch_state_t enum {FETCH_DRAIN, FETCH_REQ, FETCH_WAIT}.
  - INST_BYTES = 4 constant for the PC increment.
- One sub-module is natural: rom_fetch_buf, the one-entry valid/ready buffer with flush input. Everything else stays in rom_fetch.

Test Plan:
- Reset, DELAY=0, inst_ready tied 1 -> mem_re first at cycle 2 after reset release with addr 0. Words appear at inst_pc 0,4,8,... with one instruction every 2 cycles.
- DELAY=3, inst_ready=1 -> mem_oe 4 cycles after each mem_re. inst_valid 5 cycles after each mem_re, then the next mem_re in the same cycle.
- Backpressure: inst_ready=0 for 10 cycles after the first word -> exactly one further... no: zero further mem_re. inst and inst_pc held at 0 and data[0]. On release, mem_re in that cycle with addr 4.
- DELAY=3, redirect to 32'h0000_0103 two cycles after mem_re(addr 8) -> returned word is dropped and stale clears. Next mem_re addr is 32'h100, and inst_pc 8 never appears.
- Redirect in the same cycle as mem_oe, with inst_valid=1 and inst_ready=0 -> mem_data dropped, inst_valid=0 next cycle, next mem_re addr is the redirect target.
- Assert reset_n=0 for 1 cycle while the ROM (DELAY=3) is one cycle into a read -> no mem_re for 4 cycles. A stray mem_oe is ignored. The first mem_re at RESET_PC is honoured by the ROM and returns rom[0].
- pc at 32'hFFFF_FFFC -> next mem_addr is 32'h0000_0000.
